// File: rtl/guess_game_fsm.sv
// Lamp-chase guess game: a one-hot lamp rotates over W positions and the player presses the matching button.
// Optional macro GUESS_SPEEDUP_EN adds a per-step tick divider that shortens with every hit.
module guess_game_fsm #(
    parameter int W         = 4,
    parameter int LIVES     = 3,
    parameter int WIN_SCORE = 8,
    parameter int DIV_INIT  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [W-1:0]                   B,
    output logic [W-1:0]                   y,
    output logic                           win,
    output logic                           lose,
    output logic [$clog2(WIN_SCORE+1)-1:0] score,
    output logic [$clog2(LIVES+1)-1:0]     lives_left
);

    localparam int PW = $clog2(W);
    localparam int SW = $clog2(WIN_SCORE + 1);
    localparam int LW = $clog2(LIVES + 1);

    typedef enum logic [2:0] {
        RUN  = 3'd0,
        HIT  = 3'd1,
        MISS = 3'd2,
        WIN  = 3'd3,
        LOSE = 3'd4
    } state_t;

    state_t        state;
    logic [PW-1:0] pos;
    logic          armed;

    logic [PW-1:0] pos_nxt;
    logic [W-1:0]  lamp_cur;
    logic [W-1:0]  lamp_nxt;
    logic [SW-1:0] score_nxt;
    logic [LW-1:0] lives_nxt;
    logic          press;
    logic          step;

    function automatic logic [W-1:0] onehot(input logic [PW-1:0] p);
        onehot = W'(1) << p;
    endfunction

    assign pos_nxt   = (pos == PW'(W - 1)) ? '0 : pos + PW'(1);
    assign lamp_cur  = onehot(pos);
    assign lamp_nxt  = onehot(pos_nxt);
    assign score_nxt = score + SW'(1);
    assign lives_nxt = lives_left - LW'(1);
    // A press only counts once per release; a held button is ignored until B returns to 0.
    assign press     = (B != '0) && armed;

`ifdef GUESS_SPEEDUP_EN
    localparam int DW = $clog2(DIV_INIT + 1);

    logic [DW-1:0] div;
    logic [DW-1:0] step_cnt;

    assign step = (step_cnt == div - DW'(1));
`else
    assign step = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pos        <= '0;
            y          <= W'(1);
            score      <= '0;
            lives_left <= LW'(LIVES);
            win        <= 1'b0;
            lose       <= 1'b0;
            armed      <= 1'b1;
`ifdef GUESS_SPEEDUP_EN
            div        <= DW'(DIV_INIT);
            step_cnt   <= '0;
`endif
        end else if (en) begin
            case (state)
                RUN: begin
                    if (!press) begin
                        if (B == '0)
                            armed <= 1'b1;
                        if (step) begin
                            pos <= pos_nxt;
                            y   <= lamp_nxt;
                        end
`ifdef GUESS_SPEEDUP_EN
                        step_cnt <= step ? '0 : step_cnt + DW'(1);
`endif
                    end else begin
                        armed <= 1'b0;
                        if (B == lamp_cur) begin
                            score <= score_nxt;
                            y     <= '1;
`ifdef GUESS_SPEEDUP_EN
                            if (div > DW'(1))
                                div <= div - DW'(1);
`endif
                            if (score_nxt == SW'(WIN_SCORE)) begin
                                state <= WIN;
                                win   <= 1'b1;
                            end else begin
                                state <= HIT;
                            end
                        end else begin
                            lives_left <= lives_nxt;
                            y          <= '0;
                            if (lives_nxt == '0) begin
                                state <= LOSE;
                                lose  <= 1'b1;
                            end else begin
                                state <= MISS;
                            end
                        end
                    end
                end

                HIT, MISS: begin
                    // Flash lasts one tick; buttons are not judged, only released.
                    if (B == '0)
                        armed <= 1'b1;
                    state <= RUN;
                    pos   <= '0;
                    y     <= W'(1);
`ifdef GUESS_SPEEDUP_EN
                    step_cnt <= '0;
`endif
                end

                default: begin
                    // WIN and LOSE are terminal until reset.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: doc/guess_game_fsm.md
Name: guess_game_fsm

Overview:
- Parametrised successor to the 4-lamp guess FSM: one-hot lamp rotates across W positions; the player presses the button matching the lit lamp.
- Tracks score and remaining lives; a correct or wrong press no longer ends the game immediately.
- Sits between the button synchroniser/debouncer and the LED driver; advanced by the shared slow-tick enable from the clock divider.

Parameters:
- W, 4, number of lamps and buttons (≥2).
- LIVES, 3, wrong presses allowed before LOSE (1..15).
- WIN_SCORE, 8, correct presses needed for WIN (1..255).
- DIV_INIT, 4, ticks per lamp step at game start (used only with the optional feature; ≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  one-cycle game tick from the clock divider; all state changes except reset happen only on cycles with en=1.
- B  in  W  debounced buttons, bit i pairs with lamp i.
- y  out  W  lamp outputs (registered).
- win  out  1  high in WIN state.
- lose  out  1  high in LOSE state.
- score  out  $clog2(WIN_SCORE+1)  correct presses so far.
- lives_left  out  $clog2(LIVES+1)  remaining lives.

Behaviour:
- Reset (rst=1 at a clk edge, overrides en): state=RUN, pos=0, y=one-hot bit 0, score=0, lives_left=LIVES, win=0, lose=0, armed=1.
- States: RUN, HIT, MISS, WIN, LOSE. All evaluation is on en=1 cycles; outputs are updated on the same clock edge.
- RUN, tick with B==0: armed<=1; pos advances pos+1, wrapping W-1→0; y=one-hot(pos).
- RUN, tick with B!=0 and armed=0: press ignored; pos advances normally. A held button scores once only.
- RUN, tick with B!=0 and armed=1: armed<=0.
  - B == one-hot(pos) is a hit: score+1. If the new score equals WIN_SCORE, go to WIN; otherwise go to HIT.
  - Any other nonzero B, including multiple bits, is a miss: lives_left-1. If the new value is 0, go to LOSE; otherwise go to MISS.
- HIT: y=all ones for exactly one tick. The next tick returns to RUN with pos=0.
- MISS: y=all zeros for exactly one tick. The next tick returns to RUN with pos=0.
- In HIT/MISS, B is not evaluated, but a tick with B==0 sets armed.
- WIN: y=all ones, win=1. LOSE: y=all zeros, lose=1. Both are terminal until rst. score and lives_left freeze.
- Width rules: score never exceeds WIN_SCORE; lives_left never underflows.
- en=0: all registers hold.
- Latency: y, win and lose change one clk edge after the qualifying en cycle.

Optional Feature:
- Macro: GUESS_SPEEDUP_EN.
- Defined: a step counter makes pos advance only every `div` RUN ticks. `div` starts at DIV_INIT and decrements by 1 on each hit, saturating at 1. The step counter clears when entering RUN and on reset. Button evaluation still happens on every RUN tick.
- Undefined: pos advances on every RUN tick; there is no divider logic.

Test Plan:
- Reset, then 5 ticks with B=0 at W=4 → y sequence 0001,0010,0100,1000,0001 (wrap); score=0, lives_left=3.
- With y=0100, tick with B=0100 → HIT (y=1111) for 1 tick, then y=0001, score=1.
- With y=0010, tick with B=1000 → MISS (y=0000) for 1 tick, lives_left=2. Repeat misses until lives_left=0 → lose=1, held for 10 further ticks.
- Hold B=0001 over 3 ticks starting when y=0001 → exactly one hit (score=1). With speedup undefined, the subsequent held ticks are ignored and pos advances.
- Score WIN_SCORE=8 hits → win=1, y=1111, score=8 held. Assert rst with en=0 → all reset values on the next edge.
- GUESS_SPEEDUP_EN, DIV_INIT=4 → 4 ticks per step initially; after 3 hits, 1 tick per step; after a 4th hit it stays at 1.
